// File: rtl/jtag_dma_pkg.sv
// Shared types and defaults for the JTAG chain1 DMA engine.
// Holds the engine state encoding and the beat address helper.
package jtag_dma_pkg;

    localparam int WORD_BYTES         = 4;
    localparam int DEF_BLOCK_WORDS    = 256;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_WR_BEAT,
        ST_RD_BEAT,
        ST_RD_STORE,
        ST_DONE
    } dma_state_e;

    // Byte address of beat idx; 32-bit arithmetic wraps modulo 2^32.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * WORD_BYTES;
    endfunction

endpackage

// File: rtl/jtag_dma_engine_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise_o is combinational from the synchronized level, one cycle wide.
module sync_edge_detect (
    input  logic clock,
    input  logic nReset,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = async_i;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/jtag_dma_engine.sv
// System-clock DMA responder for JTAG chain1: moves one block between the
// DMA-side ping-pong bank and the system bus, one beat at a time.
module jtag_dma_engine
    import jtag_dma_pkg::*;
#(
    parameter int BLOCK_WORDS    = DEF_BLOCK_WORDS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [31:0] dma_address,
    input  logic [3:0]  dma_byte_enable,
    input  logic        dma_data_ready,
    input  logic        dma_readReady,
    output logic        switch_ready,
    output logic [7:0]  buf_address,
    output logic        buf_writeEnable,
    output logic [31:0] buf_dataIn,
    input  logic [31:0] buf_dataOut,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [31:0] bus_address,
    output logic        bus_write,
    output logic [3:0]  bus_byteEnable,
    output logic [31:0] bus_dataOut,
    output logic        bus_valid,
    input  logic        bus_ack,
    input  logic [31:0] bus_dataIn,
    input  logic        bus_error,
    output logic        dma_busy,
    output logic        dma_error
);

    localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    dma_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       base_q, base_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              pend_wr_q, pend_wr_d;
    logic              pend_rd_q, pend_rd_d;
    logic              dir_wr_q, dir_wr_d;

    logic wr_rise, rd_rise;
    logic counting, tmo_hit, start;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^dma_address[1:0];

    sync_edge_detect u_sync_wr (
        .clock   (clock),
        .nReset  (nReset),
        .async_i (dma_data_ready),
        .rise_o  (wr_rise)
    );

    sync_edge_detect u_sync_rd (
        .clock   (clock),
        .nReset  (nReset),
        .async_i (dma_readReady),
        .rise_o  (rd_rise)
    );

    assign counting = (state_q == ST_REQ) || (state_q == ST_WR_BEAT) || (state_q == ST_RD_BEAT);
    assign tmo_hit  = counting && (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        dir_wr_d  = dir_wr_q;
        // Edges are always latched; IDLE clears whichever one it serves.
        pend_wr_d = pend_wr_q | wr_rise;
        pend_rd_d = pend_rd_q | rd_rise;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_wr_d) begin
                    dir_wr_d  = 1'b1;
                    pend_wr_d = 1'b0;
                    start     = 1'b1;
                end else if (pend_rd_d) begin
                    dir_wr_d  = 1'b0;
                    pend_rd_d = 1'b0;
                    start     = 1'b1;
                end
                if (start) begin
                    state_d = ST_REQ;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    base_d  = {dma_address[31:2], 2'b00};
                    be_d    = dma_byte_enable;
                end
            end
            ST_REQ: begin
                if (bus_grant) begin
                    state_d = dir_wr_q ? ST_FETCH : ST_RD_BEAT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_FETCH: begin
                state_d = ST_WR_BEAT;
            end
            ST_WR_BEAT: begin
                if (bus_ack) begin
                    if (bus_error) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_BEAT: begin
                if (bus_ack) begin
                    if (bus_error) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rdata_d = bus_dataIn;
                        state_d = ST_RD_STORE;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_STORE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD_BEAT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tmo_d = (!counting || (state_d != state_q)) ? '0 : tmo_q + 1'b1;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
            dir_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            dir_wr_q  <= dir_wr_d;
        end
    end

    assign switch_ready = (state_q == ST_IDLE) && !wr_rise && !rd_rise && !pend_wr_q && !pend_rd_q;
    assign bus_request  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign dma_busy     = bus_request;
    assign dma_error    = err_q;

    assign bus_valid      = (state_q == ST_WR_BEAT) || (state_q == ST_RD_BEAT);
    assign bus_write      = (state_q == ST_WR_BEAT);
    assign bus_address    = bus_valid ? beat_addr(base_q, 32'(idx_q)) : '0;
    assign bus_byteEnable = bus_valid ? be_q : 4'h0;
    // Buffer read port is registered and buf_address holds through the beat.
    assign bus_dataOut    = bus_write ? buf_dataOut : '0;

    assign buf_address     = 8'(idx_q);
    assign buf_writeEnable = (state_q == ST_RD_STORE);
    assign buf_dataIn      = rdata_q;

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Directed bench for jtag_dma_engine with BLOCK_WORDS=4, TIMEOUT_CYCLES=16.
// Models a registered buffer read port and a bus slave with settable ack latency.
module tb_jtag_dma_engine;

    localparam int BW = 4;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic [31:0] dma_address = '0;
    logic [3:0]  dma_byte_enable = '0;
    logic        dma_data_ready = 1'b0;
    logic        dma_readReady = 1'b0;
    logic        switch_ready;
    logic [7:0]  buf_address;
    logic        buf_writeEnable;
    logic [31:0] buf_dataIn;
    logic [31:0] buf_dataOut = '0;
    logic        bus_request;
    logic        bus_grant;
    logic [31:0] bus_address;
    logic        bus_write;
    logic [3:0]  bus_byteEnable;
    logic [31:0] bus_dataOut;
    logic        bus_valid;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_dataIn = '0;
    logic        bus_error = 1'b0;
    logic        dma_busy;
    logic        dma_error;

    jtag_dma_engine #(.BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .nReset(nReset),
        .dma_address(dma_address), .dma_byte_enable(dma_byte_enable),
        .dma_data_ready(dma_data_ready), .dma_readReady(dma_readReady),
        .switch_ready(switch_ready),
        .buf_address(buf_address), .buf_writeEnable(buf_writeEnable),
        .buf_dataIn(buf_dataIn), .buf_dataOut(buf_dataOut),
        .bus_request(bus_request), .bus_grant(bus_grant),
        .bus_address(bus_address), .bus_write(bus_write),
        .bus_byteEnable(bus_byteEnable), .bus_dataOut(bus_dataOut),
        .bus_valid(bus_valid), .bus_ack(bus_ack), .bus_dataIn(bus_dataIn),
        .bus_error(bus_error), .dma_busy(dma_busy), .dma_error(dma_error)
    );

    always #5 clock = ~clock;

    logic        grant_en = 1'b1;
    logic        no_ack = 1'b0;
    int          ack_lat = 0;
    int          err_beat = -1;
    int          beat_base = 0;
    int          cyc = 0;
    int          err_cyc = 0;
    int          wcnt = 0;

    logic [31:0] mem [256];
    int          nb = 0;
    logic [31:0] b_addr [64];
    logic [31:0] b_dat  [64];
    logic        b_wr   [64];
    logic [3:0]  b_be   [64];
    int          nw = 0;
    logic [7:0]  w_idx  [64];
    logic [31:0] w_dat  [64];

    int nvec = 0;
    int nerr = 0;

    assign bus_grant = bus_request & grant_en;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) buf_dataOut <= mem[buf_address];

    // Bus slave and buffer write monitor, both sampled on the falling edge.
    always @(negedge clock) begin
        if (bus_valid && !no_ack && wcnt == ack_lat) begin
            bus_ack    = 1'b1;
            bus_error  = (nb == err_beat);
            bus_dataIn = 32'hA0 + 32'(nb - beat_base);
            if (bus_error) err_cyc = cyc;
            if (nb < 64) begin
                b_addr[nb] = bus_address;
                b_dat[nb]  = bus_write ? bus_dataOut : bus_dataIn;
                b_wr[nb]   = bus_write;
                b_be[nb]   = bus_byteEnable;
            end
            nb++;
            wcnt = 0;
        end else begin
            bus_ack   = 1'b0;
            bus_error = 1'b0;
            wcnt      = bus_valid ? wcnt + 1 : 0;
        end
        if (buf_writeEnable && nw < 64) begin
            w_idx[nw] = buf_address;
            w_dat[nw] = buf_dataIn;
            nw++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Raise the requested levels, then stop at the falling edge after bus_request is due.
    task automatic go(input logic wr, input logic rd);
        @(negedge clock);
        dma_data_ready = wr;
        dma_readReady  = rd;
        repeat (3) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_idle(output int at);
        int ok;
        ok = 0;
        at = 0;
        for (int k = 0; k < 400; k++) begin
            if (switch_ready) begin
                ok = 1;
                at = cyc;
                break;
            end
            @(negedge clock);
        end
        chk("idle_reached", 32'(ok), 1);
    endtask

    task automatic drop_levels();
        dma_data_ready = 1'b0;
        dma_readReady  = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_swr"},   32'(switch_ready), 1);
        chk({tag, "_req"},   32'(bus_request), 0);
        chk({tag, "_valid"}, 32'(bus_valid), 0);
        chk({tag, "_busy"},  32'(dma_busy), 0);
        chk({tag, "_err"},   32'(dma_error), 0);
        chk({tag, "_bwe"},   32'(buf_writeEnable), 0);
        chk({tag, "_baddr"}, bus_address, 0);
    endtask

    localparam logic [31:0] WRAP_EXP [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    initial begin
        int b0, w0, at, cnt, found;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("rst");
        nReset = 1'b1;
        repeat (2) @(negedge clock);

        // Write block: 4 beats from 0x1000, latency and no-retrigger checks
        for (int i = 0; i < 4; i++) mem[i] = 32'h11 * (i + 1);
        dma_address = 32'h1000;
        dma_byte_enable = 4'hF;
        b0 = nb;
        beat_base = nb;
        @(negedge clock);
        dma_data_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("lat2_req", 32'(bus_request), 0);
        chk("lat2_swr", 32'(switch_ready), 0);
        @(posedge clock);
        @(negedge clock);
        chk("lat3_req", 32'(bus_request), 1);
        chk("lat3_busy", 32'(dma_busy), 1);
        wait_idle(at);
        chk("wr_nbeats", 32'(nb - b0), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr_addr%0d", k), b_addr[b0+k], 32'h1000 + 32'(4 * k));
            chk($sformatf("wr_data%0d", k), b_dat[b0+k], 32'h11 * 32'(k + 1));
            chk($sformatf("wr_dir%0d", k), 32'(b_wr[b0+k]), 1);
        end
        chk("wr_be", 32'(b_be[b0]), 32'hF);
        chk("wr_err", 32'(dma_error), 0);
        repeat (6) @(negedge clock);
        chk("held_level_nbeats", 32'(nb - b0), 4);
        chk("held_level_req", 32'(bus_request), 0);
        drop_levels();

        // Read block: slave returns A0..A3
        dma_address = 32'h2000;
        dma_byte_enable = 4'h3;
        b0 = nb;
        w0 = nw;
        beat_base = nb;
        go(1'b0, 1'b1);
        wait_idle(at);
        chk("rd_nbeats", 32'(nb - b0), 4);
        chk("rd_nwrites", 32'(nw - w0), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_idx%0d", k), 32'(w_idx[w0+k]), 32'(k));
            chk($sformatf("rd_word%0d", k), w_dat[w0+k], 32'hA0 + 32'(k));
            chk($sformatf("rd_addr%0d", k), b_addr[b0+k], 32'h2000 + 32'(4 * k));
        end
        chk("rd_dir", 32'(b_wr[b0]), 0);
        chk("rd_be", 32'(b_be[b0]), 32'h3);
        chk("rd_err", 32'(dma_error), 0);
        drop_levels();

        // Simultaneous requests: write block completes before any read beat
        dma_address = 32'h3000;
        dma_byte_enable = 4'hF;
        b0 = nb;
        beat_base = nb + 4;
        go(1'b1, 1'b1);
        wait_idle(at);
        chk("sim_nbeats", 32'(nb - b0), 8);
        chk("sim_beat3_wr", 32'(b_wr[b0+3]), 1);
        chk("sim_beat4_rd", 32'(b_wr[b0+4]), 0);
        chk("sim_beat4_addr", b_addr[b0+4], 32'h3000);
        drop_levels();

        // Bus error on beat 2 of 4
        dma_address = 32'h4000;
        b0 = nb;
        beat_base = nb;
        err_beat = nb + 1;
        go(1'b1, 1'b0);
        wait_idle(at);
        err_beat = -1;
        chk("err_nbeats", 32'(nb - b0), 2);
        chk("err_flag", 32'(dma_error), 1);
        chk("err_idle_cycles", 32'(at - err_cyc), 2);
        chk("err_req", 32'(bus_request), 0);
        drop_levels();

        // Ack withheld: WR_BEAT aborts after TO cycles, error flag cleared on start
        no_ack = 1'b1;
        b0 = nb;
        go(1'b1, 1'b0);
        chk("tmo_err_cleared", 32'(dma_error), 0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_valid) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        chk("tmo_valid_seen", 32'(found), 1);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus_valid) break;
            cnt++;
            @(negedge clock);
        end
        chk("tmo_len", 32'(cnt), TO);
        wait_idle(at);
        chk("tmo_err", 32'(dma_error), 1);
        chk("tmo_nbeats", 32'(nb - b0), 0);
        no_ack = 1'b0;
        drop_levels();

        // Address wrap at 2^32 with one-cycle ack latency
        ack_lat = 1;
        dma_address = 32'hFFFF_FFF8;
        b0 = nb;
        beat_base = nb;
        go(1'b1, 1'b0);
        wait_idle(at);
        chk("wrap_nbeats", 32'(nb - b0), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrap_addr%0d", k), b_addr[b0+k], WRAP_EXP[k]);
        drop_levels();

        // Reset while beat 2 is on the bus
        b0 = nb;
        go(1'b1, 1'b0);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clock);
            #2;
            if (bus_valid && (nb - b0) == 1) begin
                found = 1;
                break;
            end
        end
        chk("mid_rst_beat2_seen", 32'(found), 1);
        nReset = 1'b0;
        dma_data_ready = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) @(negedge clock);
        nReset = 1'b1;
        repeat (10) @(negedge clock);
        chk("mid_rst_nbeats", 32'(nb - b0), 1);
        chk("mid_rst_req", 32'(bus_request), 0);
        chk("mid_rst_swr", 32'(switch_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
